// File: rtl/logic_stream_fifo_single_clock.sv
// logic_stream_fifo_single_clock: single-clock valid/ready FIFO of CAPACITY x WIDTH words; ports aclk, areset_n, rx_tvalid/rx_tdata/rx_tready (in), tx_tready/tx_tvalid/tx_tdata (out)
module logic_stream_fifo_single_clock #(
  parameter int WIDTH = 1,
  parameter int CAPACITY = 256
) (
  input  logic             aclk,
  input  logic             areset_n,
  input  logic             rx_tvalid,
  input  logic [WIDTH-1:0] rx_tdata,
  output logic             rx_tready,
  input  logic             tx_tready,
  output logic             tx_tvalid,
  output logic [WIDTH-1:0] tx_tdata
);
  localparam int PW = $clog2(CAPACITY);
  localparam int CW = $clog2(CAPACITY + 1);
  localparam logic [PW-1:0] LAST = PW'(CAPACITY - 1);
  if (CAPACITY < 4 || WIDTH < 1) begin : g_bad_params
    $error("logic_stream_fifo_single_clock: CAPACITY must be >= 4 and WIDTH >= 1");
  end
  logic [WIDTH-1:0] mem [CAPACITY];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, next_count;
  logic push, pop;
  assign push = rx_tvalid & rx_tready;
  assign pop = tx_tvalid & tx_tready;
  assign next_count = count + CW'(push) - CW'(pop);
  assign tx_tdata = mem[rd_ptr];
  always_ff @(posedge aclk or negedge areset_n)
    if (!areset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rx_tready <= 1'b0;
      tx_tvalid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      count <= next_count;
      rx_tready <= next_count < CW'(CAPACITY);
      tx_tvalid <= next_count != '0;
    end
  always_ff @(posedge aclk)
    if (push) mem[wr_ptr] <= rx_tdata;
endmodule

// File: tb/tb_logic_stream_fifo_single_clock.sv
// tb_logic_stream_fifo_single_clock: scoreboard bench for the single-clock stream FIFO (CAPACITY=4, WIDTH=8)
module tb_logic_stream_fifo_single_clock;
  localparam int W = 8;
  localparam int CAP = 4;
  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  logic rx_tvalid = 1'b0;
  logic [W-1:0] rx_tdata = '0;
  logic rx_tready;
  logic tx_tready = 1'b0;
  logic tx_tvalid;
  logic [W-1:0] tx_tdata;
  int n_cmp = 0;
  int n_err = 0;
  int n_pops = 0;
  logic [W-1:0] sb [$];
  logic [W-1:0] exp_w;
  logic_stream_fifo_single_clock #(.WIDTH(W), .CAPACITY(CAP)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata), .rx_tready(rx_tready),
    .tx_tready(tx_tready), .tx_tvalid(tx_tvalid), .tx_tdata(tx_tdata)
  );
  always #5 aclk = ~aclk;
  always @(negedge aclk)
    if (!areset_n) sb.delete();
    else begin
      if (tx_tvalid && tx_tready) begin
        n_cmp++;
        n_pops++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL pop_order: popped %h but scoreboard is empty", tx_tdata);
        end else begin
          exp_w = sb.pop_front();
          if (tx_tdata !== exp_w) begin
            n_err++;
            $display("FAIL pop_order: got %h expected %h", tx_tdata, exp_w);
          end
        end
      end
      if (rx_tvalid && rx_tready) sb.push_back(rx_tdata);
    end
  task automatic step();
    @(posedge aclk);
    #1;
  endtask
  task automatic drain(input string name);
    bit done = 0;
    tx_tready = 1'b1;
    for (int i = 0; i < 40 && !done; i++)
      if (!tx_tvalid) done = 1;
      else step();
    tx_tready = 1'b0;
    n_cmp++;
    if (!done || sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: done=%0d leftover=%0d required done=1 leftover=0", name, done, sb.size());
    end
  endtask
  task automatic fill(input int base, input int n);
    tx_tready = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_tvalid = 1'b1;
      rx_tdata = W'(base + i);
      step();
    end
    rx_tvalid = 1'b0;
  endtask
  task automatic test_reset();
    areset_n = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (rx_tready !== 1'b0 || tx_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: rx_tready=%b tx_tvalid=%b required 0 0", rx_tready, tx_tvalid);
    end
    areset_n = 1'b1;
    step();
    n_cmp++;
    if (rx_tready !== 1'b1 || tx_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: rx_tready=%b tx_tvalid=%b required 1 0", rx_tready, tx_tvalid);
    end
  endtask
  task automatic test_single_backpressure();
    fill(8'hA5, 1);
    n_cmp++;
    if (tx_tvalid !== 1'b1 || tx_tdata !== 8'hA5) begin
      n_err++;
      $display("FAIL single_latency: tx_tvalid=%b tx_tdata=%h required 1 a5", tx_tvalid, tx_tdata);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (tx_tvalid !== 1'b1 || tx_tdata !== 8'hA5) begin
        n_err++;
        $display("FAIL single_hold%0d: tx_tvalid=%b tx_tdata=%h required 1 a5", i, tx_tvalid, tx_tdata);
      end
    end
    drain("single");
  endtask
  task automatic test_fill_drain();
    int p0 = n_pops;
    fill(1, 4);
    n_cmp++;
    if (rx_tready !== 1'b0) begin
      n_err++;
      $display("FAIL full_ready: rx_tready=%b required 0", rx_tready);
    end
    rx_tvalid = 1'b1;
    rx_tdata = 8'd5;
    repeat (3) step();
    rx_tvalid = 1'b0;
    n_cmp++;
    if (rx_tready !== 1'b0 || sb.size() != 4) begin
      n_err++;
      $display("FAIL full_reject: rx_tready=%b stored=%0d required 0 4", rx_tready, sb.size());
    end
    drain("fill");
    n_cmp++;
    if (n_pops - p0 != 4 || tx_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL fill_count: pops=%0d tx_tvalid=%b required 4 0", n_pops - p0, tx_tvalid);
    end
  endtask
  task automatic test_back_to_back();
    int p0 = n_pops;
    int idx = 0;
    int stalls = 0;
    int cyc = 0;
    tx_tready = 1'b1;
    rx_tvalid = 1'b1;
    while (idx < 20 && cyc < 60) begin
      rx_tdata = W'(idx);
      if (cyc > 0 && (!rx_tready || !tx_tvalid)) stalls++;
      if (rx_tready) idx++;
      step();
      cyc++;
    end
    rx_tvalid = 1'b0;
    n_cmp++;
    if (idx != 20 || stalls != 0) begin
      n_err++;
      $display("FAIL stream_flow: accepted=%0d stalls=%0d required 20 0", idx, stalls);
    end
    drain("stream");
    n_cmp++;
    if (n_pops - p0 != 20) begin
      n_err++;
      $display("FAIL stream_count: pops=%0d required 20", n_pops - p0);
    end
  endtask
  task automatic test_full_pop();
    int p0;
    fill(8'h10, 4);
    p0 = n_pops;
    rx_tvalid = 1'b1;
    rx_tdata = 8'h77;
    tx_tready = 1'b1;
    step();
    tx_tready = 1'b0;
    rx_tvalid = 1'b0;
    n_cmp++;
    if (n_pops - p0 != 1 || rx_tready !== 1'b1 || sb.size() != 3) begin
      n_err++;
      $display("FAIL full_pop: pops=%0d rx_tready=%b stored=%0d required 1 1 3", n_pops - p0, rx_tready, sb.size());
    end
    fill(8'h77, 1);
    n_cmp++;
    if (rx_tready !== 1'b0 || sb.size() != 4) begin
      n_err++;
      $display("FAIL full_refill: rx_tready=%b stored=%0d required 0 4", rx_tready, sb.size());
    end
    drain("fullpop");
  endtask
  task automatic test_reset_mid();
    fill(8'h50, 3);
    areset_n = 1'b0;
    #1;
    n_cmp++;
    if (tx_tvalid !== 1'b0 || rx_tready !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_async: tx_tvalid=%b rx_tready=%b required 0 0", tx_tvalid, rx_tready);
    end
    repeat (2) step();
    areset_n = 1'b1;
    step();
    n_cmp++;
    if (tx_tvalid !== 1'b0 || rx_tready !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_empty: tx_tvalid=%b rx_tready=%b required 0 1", tx_tvalid, rx_tready);
    end
    fill(8'h3C, 1);
    n_cmp++;
    if (tx_tvalid !== 1'b1 || tx_tdata !== 8'h3C) begin
      n_err++;
      $display("FAIL midreset_first: tx_tvalid=%b tx_tdata=%h required 1 3c", tx_tvalid, tx_tdata);
    end
    drain("midreset");
  endtask
  initial begin
    test_reset();
    test_single_backpressure();
    test_fill_drain();
    test_back_to_back();
    test_full_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/logic_stream_fifo_single_clock.md
Name: logic_stream_fifo_single_clock

Overview:
- Single-clock AXI4-Stream FIFO buffer.
- Same rx/tx stream interface as the clock-domain-crossing wrapper family. Used where producer and consumer share one clock, so no synchronizers are needed.
- Stores up to CAPACITY words of WIDTH bits and preserves their order.
- Provides valid/ready backpressure on both sides.

Parameters:
- WIDTH, 1: bit width of rx_tdata and tx_tdata. Must be >= 1.
- CAPACITY, 256: maximum number of stored words. Must be >= 4; violation is a design-rule error at elaboration. Any integer is allowed; power of two is not required.

Ports:
- aclk  input  1  clock; all state updates on its rising edge.
- areset_n  input  1  asynchronous active-low reset.
- rx_tvalid  input  1  producer has a word.
- rx_tdata  input  WIDTH  producer word.
- rx_tready  output  1  FIFO can accept a word.
- tx_tready  input  1  consumer can accept a word.
- tx_tvalid  output  1  FIFO presents a word.
- tx_tdata  output  WIDTH  presented word.

Interface: one clock; reset is asynchronous and active-low (aclk, areset_n).

Behaviour:
- State:
  - storage array of CAPACITY x WIDTH, not reset;
  - write pointer and read pointer, each 0..CAPACITY-1, wrapping from CAPACITY-1 to 0;
  - occupancy count, 0..CAPACITY.
- Reset (areset_n low, asynchronous assert; synchronous effect on release):
  - pointers and count = 0;
  - rx_tready = 0 and tx_tvalid = 0 while reset is asserted.
  - tx_tdata is don't-care whenever tx_tvalid = 0.
- Push: rx_tvalid && rx_tready at a rising edge. Writes rx_tdata at the write pointer and advances the write pointer.
- Pop: tx_tvalid && tx_tready at a rising edge. Advances the read pointer.
- Count update:
  - push only: +1;
  - pop only: -1;
  - both: unchanged.
- Outputs rx_tready and tx_tvalid are registered from the next count:
  - rx_tready = (next_count < CAPACITY);
  - tx_tvalid = (next_count != 0).
- First cycle after reset release: rx_tready = 1, tx_tvalid = 0.
- tx_tdata = storage[read pointer]. This is a combinational read of registered storage.
- Latency: a word pushed at edge N is visible with tx_tvalid = 1 after edge N, i.e. one cycle, when the FIFO was empty.
- Full (count = CAPACITY):
  - rx_tready = 0 and rx_tvalid is ignored.
  - A pop in the full state raises rx_tready after that edge. No push can occur in the same cycle as leaving full.
- Empty (count = 0):
  - tx_tvalid = 0 and tx_tready is ignored. No pop occurs.
  - A push into an empty FIFO never bypasses storage.
- Simultaneous push and pop when 0 < count < CAPACITY: both occur and count is unchanged. The read pointer must not overtake the write pointer.
- Stream rule: while tx_tvalid = 1 and tx_tready = 0, tx_tvalid and tx_tdata hold stable.
- Ordering: strict FIFO. No word is lost, duplicated or reordered.
- Pointer wrap: after CAPACITY pushes the write pointer returns to 0. The full/empty distinction comes only from the count.
- Reset mid-operation: all stored words are discarded. The FIFO behaves as empty after release, and no stale word is ever presented.

Test Plan:
- Reset, then release with CAPACITY=4 -> rx_tready=0 and tx_tvalid=0 during reset; after first edge rx_tready=1, tx_tvalid=0.
- Push 0xA5 (WIDTH=8) with tx_tready=0 -> tx_tvalid=1, tx_tdata=0xA5 one cycle later; both held stable for 10 cycles of backpressure.
- Push 1,2,3,4 back-to-back with CAPACITY=4, tx_tready=0 -> rx_tready=0 after 4th accept; 5th word (5) not accepted. Then drain -> outputs 1,2,3,4 in order, then tx_tvalid=0.
- Continuous rx_tvalid and tx_tready for 20 words 0..19, CAPACITY=4 -> all 20 emerge in order, pointers wrap 5 times, no stall after the first cycle.
- Full FIFO, tx_tready=1 for one cycle -> exactly one pop; rx_tready=1 the next cycle; count returns to 4 after one more push.
- Assert areset_n low with 3 words stored -> tx_tvalid=0 immediately; after release, FIFO empty; new word 0x3C emerges first.
